axi_inf_write_slave_core: RTL

AXI_INF_WRITE_SLAVE_CORE -- requirements
Module: axi_inf_write_slave_core

---
 rtl/axi_inf_write_slave_core.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_inf_write_slave_core.sv
// AXI write slave core: one burst at a time, beats streamed with zero latency to a sink port.
// Optional macro AXI_WR_SLAVE_WLAST_CHECK_EN adds beat-count vs wlast checking with SLVERR.
module axi_inf_write_slave_core #(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 8,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic               axi_aclk,
  input  logic               axi_resetn,
  input  logic [IDSIZE-1:0]  axi_awid,
  input  logic [ASIZE-1:0]   axi_awaddr,
  input  logic [LSIZE-1:0]   axi_awlen,
  input  logic [2:0]         axi_awsize,
  input  logic [1:0]         axi_awburst,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [DSIZE-1:0]   axi_wdata,
  input  logic [DSIZE/8-1:0] axi_wstrb,
  input  logic               axi_wlast,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  output logic [IDSIZE-1:0]  axi_bid,
  output logic [1:0]         axi_bresp,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  output logic               mem_wr_en,
  output logic [ASIZE-1:0]   mem_addr,
  output logic [DSIZE-1:0]   mem_wdata,
  output logic [DSIZE/8-1:0] mem_wstrb,
  input  logic               sink_full,
  output logic               busy,
  output logic               burst_done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  state_t             state, state_next;
  logic               awready_q;
  logic               burst_done_q;
  logic [IDSIZE-1:0]  id_q;
  logic [ASIZE-1:0]   addr_q;
  logic [LSIZE-1:0]   len_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic [LSIZE:0]     cnt_q;
  logic [1:0]         resp_q;
  logic [ASIZE-1:0]   step;
  logic               aw_hs;
  logic               beat;
  logic               end_beat;
  logic               beat_err;

  // Handshake rule on every channel: a transfer happens in the cycle where valid and ready are both high.
  assign aw_hs      = axi_awvalid & awready_q;
  assign axi_wready = (state == DATA) & ~sink_full;
  assign beat       = axi_wvalid & axi_wready;
  assign step       = ASIZE'(1) << size_q;

`ifdef AXI_WR_SLAVE_WLAST_CHECK_EN
  logic cnt_match;
  assign cnt_match = (cnt_q == {1'b0, len_q});
  // Burst ends at the first of wlast or the final counted beat; disagreement is an error.
  assign end_beat  = beat & (axi_wlast | cnt_match);
  assign beat_err  = axi_wlast ^ cnt_match;
`else
  logic unused_len;
  assign unused_len = ^len_q;
  assign end_beat   = beat & axi_wlast;
  assign beat_err   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_hs) state_next = DATA;
      DATA:    if (end_beat) state_next = RESP;
      RESP:    if (axi_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state        <= IDLE;
      awready_q    <= 1'b0;
      burst_done_q <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      resp_q       <= RESP_OKAY;
    end else begin
      state        <= state_next;
      awready_q    <= (state_next == IDLE);
      burst_done_q <= (state == RESP) & axi_bready;
      if (aw_hs) begin
        id_q    <= axi_awid;
        addr_q  <= axi_awaddr;
        len_q   <= axi_awlen;
        size_q  <= axi_awsize;
        burst_q <= axi_awburst;
        cnt_q   <= '0;
        resp_q  <= RESP_OKAY;
      end
      if (beat) begin
        cnt_q <= cnt_q + (LSIZE+1)'(1);
        // WRAP and reserved encodings advance like INCR.
        if (burst_q != BURST_FIXED) addr_q <= addr_q + step;
        if (end_beat && beat_err) resp_q <= RESP_SLVERR;
      end
    end
  end

  assign axi_awready = awready_q;
  assign axi_bvalid  = (state == RESP);
  assign axi_bid     = id_q;
  assign axi_bresp   = resp_q;
  assign mem_wr_en   = beat;
  assign mem_addr    = addr_q;
  assign mem_wdata   = axi_wdata;
  assign mem_wstrb   = axi_wstrb;
  assign busy        = (state != IDLE);
  assign burst_done  = burst_done_q;
  assign dbg_state   = state;

endmodule
